// File: rtl/keypad_scanner.sv
// Purpose : 4x4 matrix keypad column scanner with row synchronizer, press/release debounce and key strobe.
// Latency : press accepted 2 clk (sync) + DEBOUNCE_TICKS scan ticks after it is stable at the driven column.
// Backpr. : none; new_key is a one-cycle strobe and the decoder must take it when it is high.
// Optional: define KEYPAD_AUTOREPEAT_EN to re-strobe new_key every REPEAT_TICKS ticks while a key is held.
module keypad_scanner #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_TICKS = 20,
    parameter int REPEAT_TICKS   = 50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] scan_row,
    output logic [3:0] scan_col,
    output logic       new_key,
    output logic       key_held
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DBC_MAX  = DW'(DEBOUNCE_TICKS);
    // A single matching tick is enough: accept/release on the detecting tick itself.
    localparam bit ONE_TICK = (DEBOUNCE_TICKS == 1);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    state_t        state_q;
    logic [3:0]    row_m_q;
    logic [3:0]    row_s_q;
    logic [CW-1:0] div_q;
    logic [CW-1:0] div_d;
    logic [DW-1:0] dbc_q;
    logic [DW-1:0] dbc_inc;
    logic [3:0]    cap_row_q;
    logic [3:0]    col_q;
    logic [3:0]    col_rot;
    logic [3:0]    scan_row_q;
    logic [3:0]    scan_col_q;
    logic          new_key_q;
    logic          key_held_q;
    logic          tick;
    logic [3:0]    row_low;
    logic          valid_press;
    logic          row_idle;
    logic          row_same;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_TICKS + 1);
    localparam logic [RW-1:0] REP_MAX = RW'(REPEAT_TICKS);
    logic [RW-1:0] rep_q;
    logic [RW-1:0] rep_inc;
    assign rep_inc = rep_q + RW'(1);
`else
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = ^REPEAT_TICKS;
`endif

    assign tick        = (div_q == DIV_LAST);
    assign div_d       = tick ? '0 : div_q + CW'(1);
    assign dbc_inc     = (dbc_q == DBC_MAX) ? dbc_q : dbc_q + DW'(1);
    assign col_rot     = {col_q[2:0], col_q[3]};
    assign row_low     = ~row_s_q;
    assign valid_press = (row_low != 4'b0000) && ((row_low & (row_low - 4'd1)) == 4'b0000);
    assign row_idle    = (row_s_q == 4'b1111);
    assign row_same    = (row_s_q == cap_row_q);

    // Two-flop synchronizer for the asynchronous, pulled-up row lines.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_m_q <= 4'b1111;
            row_s_q <= 4'b1111;
        end else begin
            row_m_q <= row_in;
            row_s_q <= row_m_q;
        end
    end

    // Free-running scan prescaler; tick is high for the last count of each period.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    // Scan/debounce/hold/release FSM; every decision is taken on tick, all outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= SCAN;
            col_q      <= 4'b1110;
            cap_row_q  <= 4'b1111;
            dbc_q      <= '0;
            scan_row_q <= 4'b1111;
            scan_col_q <= 4'b1111;
            new_key_q  <= 1'b0;
            key_held_q <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_q      <= '0;
`endif
        end else begin
            new_key_q <= 1'b0;
            if (tick) begin
                case (state_q)
                    SCAN: begin
                        if (valid_press) begin
                            // Column stays frozen on the one that produced the press.
                            cap_row_q <= row_s_q;
                            dbc_q     <= DW'(1);
                            if (ONE_TICK) begin
                                scan_row_q <= row_s_q;
                                scan_col_q <= col_q;
                                new_key_q  <= 1'b1;
                                key_held_q <= 1'b1;
                                state_q    <= HELD;
                            end else begin
                                state_q <= DEBOUNCE;
                            end
                        end else begin
                            col_q <= col_rot;
                        end
                    end
                    DEBOUNCE: begin
                        if (row_same) begin
                            dbc_q <= dbc_inc;
                            if (dbc_inc == DBC_MAX) begin
                                scan_row_q <= cap_row_q;
                                scan_col_q <= col_q;
                                new_key_q  <= 1'b1;
                                key_held_q <= 1'b1;
                                state_q    <= HELD;
                            end
                        end else begin
                            dbc_q   <= '0;
                            col_q   <= col_rot;
                            state_q <= SCAN;
                        end
                    end
                    HELD: begin
                        if (row_idle) begin
`ifdef KEYPAD_AUTOREPEAT_EN
                            rep_q <= '0;
`endif
                            if (ONE_TICK) begin
                                dbc_q      <= '0;
                                key_held_q <= 1'b0;
                                col_q      <= col_rot;
                                state_q    <= SCAN;
                            end else begin
                                dbc_q   <= DW'(1);
                                state_q <= RELEASE;
                            end
                        end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
                            // Extra keys are ignored; the repeat timer keeps running while held.
                            if (rep_inc == REP_MAX) begin
                                rep_q     <= '0;
                                new_key_q <= 1'b1;
                            end else begin
                                rep_q <= rep_inc;
                            end
`endif
                        end
                    end
                    RELEASE: begin
                        if (row_idle) begin
                            dbc_q <= dbc_inc;
                            if (dbc_inc == DBC_MAX) begin
                                dbc_q      <= '0;
                                key_held_q <= 1'b0;
                                col_q      <= col_rot;
                                state_q    <= SCAN;
                            end
                        end else if (row_same) begin
                            // Contact bounce: back to held without a new strobe.
                            dbc_q   <= '0;
                            state_q <= HELD;
                        end else begin
                            dbc_q <= '0;
                        end
                    end
                    default: begin
                        state_q <= SCAN;
                    end
                endcase
            end
        end
    end

    assign col_out  = col_q;
    assign scan_row = scan_row_q;
    assign scan_col = scan_col_q;
    assign new_key  = new_key_q;
    assign key_held = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Purpose : directed bench for keypad_scanner with a strobe scoreboard (SCAN_DIV=4, DEBOUNCE_TICKS=3, REPEAT_TICKS=5).
// Latency : one scan tick every 4 clk; checks sampled on the falling edge.
// Backpr. : none; every new_key strobe must match the head of the expected-key queue.
module tb_keypad_scanner;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] scan_row;
    logic [3:0] scan_col;
    logic       new_key;
    logic       key_held;

    int         compared   = 0;
    int         mismatched = 0;
    logic [7:0] exp_q[$];

    keypad_scanner #(
        .SCAN_DIV      (4),
        .DEBOUNCE_TICKS(3),
        .REPEAT_TICKS  (5)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .row_in  (row_in),
        .col_out (col_out),
        .scan_row(scan_row),
        .scan_col(scan_col),
        .new_key (new_key),
        .key_held(key_held)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Each scan tick spans 4 clk; windows start on the falling edge right after reset release.
    task automatic wait_ticks(input int n);
        repeat (n * 4) @(negedge clk);
    endtask

    task automatic check_col(input string tag, input logic [3:0] exp);
        check(tag, {4'b0000, col_out}, {4'b0000, exp});
    endtask

    task automatic check_held(input string tag, input logic exp);
        check(tag, {7'b0, key_held}, {7'b0, exp});
    endtask

    task automatic check_key(input string tag, input logic [3:0] er, input logic [3:0] ec);
        check(tag, {scan_row, scan_col}, {er, ec});
    endtask

    task automatic check_reset_values(input string pfx);
        check_col({pfx, "_col"}, 4'b1110);
        check_key({pfx, "_key"}, 4'b1111, 4'b1111);
        check({pfx, "_new_key"}, {7'b0, new_key}, 8'h00);
        check_held({pfx, "_held"}, 1'b0);
    endtask

    initial begin
        logic [3:0] rot_seq[4];
        logic [3:0] bad_seq[5];
        logic [7:0] exp_key;
        rot_seq = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
        bad_seq = '{4'b0111, 4'b1110, 4'b1101, 4'b1011, 4'b0111};

        reset  = 1'b1;
        row_in = 4'b1111;

        // Scoreboard: every strobe pops one expected {row,col}; a strobe with nothing queued fails.
        fork
            forever begin
                @(negedge clk);
                if (!reset && new_key) begin
                    compared++;
                    assert (exp_q.size() != 0) else begin
                        mismatched++;
                        $error("FAIL unexpected_strobe: observed new_key=1 key=%b/%b expected no strobe",
                               scan_row, scan_col);
                    end
                    if (exp_q.size() != 0) begin
                        exp_key = exp_q.pop_front();
                        check("strobe_key", {scan_row, scan_col}, exp_key);
                        check_held("strobe_held", 1'b1);
                    end
                end
            end
        join_none

        repeat (3) @(negedge clk);
        check_reset_values("reset");
        reset = 1'b0;

        // Idle rows: column drive rotates once per tick.
        for (int i = 0; i < 4; i++) begin
            wait_ticks(1);
            check_col("rotate", rot_seq[i]);
        end

        // One-tick press at column 1110, then idle: no acceptance, scanning resumes.
        row_in = 4'b1110;
        wait_ticks(1);
        check_col("short_frozen", 4'b1110);
        row_in = 4'b1111;
        wait_ticks(1);
        check_col("short_resume", 4'b1101);
        check_key("short_key", 4'b1111, 4'b1111);
        check_held("short_held", 1'b0);

        // Key 5: row 1101 while column 1101 is driven; accepted on the third tick.
        row_in = 4'b1101;
        exp_q.push_back({4'b1101, 4'b1101});
        wait_ticks(2);
        check_held("k5_not_yet", 1'b0);
        wait_ticks(1);
        check_key("k5_key", 4'b1101, 4'b1101);
        check_held("k5_held", 1'b1);
`ifdef KEYPAD_AUTOREPEAT_EN
        exp_q.push_back({4'b1101, 4'b1101});
`endif
        wait_ticks(6);
        check_col("k5_frozen", 4'b1101);
        check_held("k5_still_held", 1'b1);

        // Release bounce: idle one tick, key back, then idle for the full debounce.
        row_in = 4'b1111;
        wait_ticks(1);
        check_held("bounce_rel1", 1'b1);
        row_in = 4'b1101;
        wait_ticks(1);
        check_held("bounce_back", 1'b1);
        row_in = 4'b1111;
        wait_ticks(2);
        check_held("rel_partial", 1'b1);
        check_col("rel_frozen", 4'b1101);
        wait_ticks(1);
        check_held("rel_done", 1'b0);
        check_col("rel_resume", 4'b1011);
        check_key("rel_retain", 4'b1101, 4'b1101);

        // Two rows low is never a valid press.
        row_in = 4'b1100;
        for (int i = 0; i < 5; i++) begin
            wait_ticks(1);
            check_col("multi_rotate", bad_seq[i]);
        end
        check_held("multi_held", 1'b0);

        // Reset asserted in the middle of debounce.
        row_in = 4'b0111;
        wait_ticks(2);
        check_col("dbc_frozen", 4'b0111);
        reset = 1'b1;
        #1;
        check_reset_values("mid_reset");
        @(negedge clk);
        row_in = 4'b1111;
        @(negedge clk);
        reset = 1'b0;
        wait_ticks(3);
        check_col("post_reset_col", 4'b0111);
        check_key("post_reset_key", 4'b1111, 4'b1111);

        // Key 0: row 0111 at column 1101, held for 10 ticks; repeats only with autorepeat.
        wait_ticks(2);
        check_col("k0_col", 4'b1101);
        row_in = 4'b0111;
        exp_q.push_back({4'b0111, 4'b1101});
        wait_ticks(3);
        check_key("k0_key", 4'b0111, 4'b1101);
        check_held("k0_held", 1'b1);
        for (int r = 0; r < 2; r++) begin
`ifdef KEYPAD_AUTOREPEAT_EN
            exp_q.push_back({4'b0111, 4'b1101});
`endif
            wait_ticks(5);
        end
        row_in = 4'b1111;
        wait_ticks(3);
        check_held("k0_released", 1'b0);
        check_key("k0_retain", 4'b0111, 4'b1101);
        wait_ticks(6);

        @(negedge clk);
        check("queue_drained", 8'(exp_q.size()), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
